// File: rtl/frame_scan_ctrl.sv
// rtl/frame_scan_ctrl.sv - frame loader and active-window raster scanner
// Streams a whole frame into the buffer, then reads back the active window row by row.
module frame_scan_ctrl #(
    parameter int FRAME_BYTES = 36300,
    parameter int HDR_BYTES   = 3330,
    parameter int ROW_STRIDE  = 330,
    parameter int ACT_W       = 300,
    parameter int ACT_H       = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    input  logic        out_ready,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    output logic        pix_valid,
    output logic [9:0]  px_cnt,
    output logic [9:0]  line_cnt,
    output logic        busy,
    output logic        load_done,
    output logic        scan_done
);

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;

    localparam logic [15:0] LAST_BYTE = 16'(FRAME_BYTES - 1);
    localparam logic [15:0] HDR       = 16'(HDR_BYTES);
    localparam logic [15:0] STRIDE    = 16'(ROW_STRIDE);
    localparam logic [9:0]  LAST_PX   = 10'(ACT_W - 1);
    localparam logic [9:0]  LAST_LINE = 10'(ACT_H - 1);

    state_t      state_q, state_d;
    logic [15:0] load_cnt_q, load_cnt_d;
    logic [15:0] row_base_q, row_base_d;
    logic [9:0]  px_cnt_q, px_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic        pix_valid_q, pix_valid_d;
    logic        load_done_q, load_done_d;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        row_base_d  = row_base_q;
        px_cnt_d    = px_cnt_q;
        line_cnt_d  = line_cnt_q;
        load_done_d = 1'b0;
        in_ready    = 1'b0;
        wr_en       = 1'b0;
        wr_data     = 8'd0;
        rd_en       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    load_cnt_d = 16'd0;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                wr_data  = in_byte;
                if (in_valid) begin
                    if (load_cnt_q == LAST_BYTE) begin
                        state_d     = SCAN;
                        load_cnt_d  = 16'd0;
                        load_done_d = 1'b1;
                        row_base_d  = HDR;
                        px_cnt_d    = 10'd0;
                        line_cnt_d  = 10'd0;
                    end else begin
                        load_cnt_d = load_cnt_q + 16'd1;
                    end
                end
            end
            SCAN: begin
                rd_en = out_ready;
                if (out_ready) begin
                    if (px_cnt_q == LAST_PX) begin
                        px_cnt_d = 10'd0;
                        if (line_cnt_q == LAST_LINE) begin
                            // Window exhausted: park counters so DONE/IDLE present zeros.
                            state_d    = DONE;
                            line_cnt_d = 10'd0;
                            row_base_d = 16'd0;
                        end else begin
                            line_cnt_d = line_cnt_q + 10'd1;
                            row_base_d = row_base_q + STRIDE;
                        end
                    end else begin
                        px_cnt_d = px_cnt_q + 10'd1;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                px_cnt_d   = 10'd0;
                line_cnt_d = 10'd0;
            end
            default: state_d = IDLE;
        endcase

        pix_valid_d = rd_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            load_cnt_q  <= 16'd0;
            row_base_q  <= 16'd0;
            px_cnt_q    <= 10'd0;
            line_cnt_q  <= 10'd0;
            pix_valid_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            row_base_q  <= row_base_d;
            px_cnt_q    <= px_cnt_d;
            line_cnt_q  <= line_cnt_d;
            pix_valid_q <= pix_valid_d;
            load_done_q <= load_done_d;
        end
    end

    assign wr_addr   = load_cnt_q;
    assign rd_addr   = row_base_q + {6'd0, px_cnt_q};
    assign px_cnt    = px_cnt_q;
    assign line_cnt  = line_cnt_q;
    assign pix_valid = pix_valid_q;
    assign load_done = load_done_q;
    assign busy      = (state_q != IDLE);
    assign scan_done = (state_q == DONE);

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// tb/tb_frame_scan_ctrl.sv - randomized self-checking bench for frame_scan_ctrl
// Instance 0 uses default geometry; instance 1 a small geometry for the abort/reload sequences.
module tb_frame_scan_ctrl;

    localparam int S_HB = 5;
    localparam int S_RS = 6;
    localparam int S_AW = 4;
    localparam int S_AH = 60;
    localparam int S_FB = 370;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, in_valid, out_ready, sel;
    logic [7:0] in_byte;
    logic       start0, start1;
    assign start0 = start & ~sel;
    assign start1 = start & sel;

    logic        d0_in_ready, d0_wr_en, d0_rd_en, d0_pix_valid, d0_busy, d0_load_done, d0_scan_done;
    logic [15:0] d0_wr_addr, d0_rd_addr;
    logic [7:0]  d0_wr_data;
    logic [9:0]  d0_px_cnt, d0_line_cnt;
    logic        d1_in_ready, d1_wr_en, d1_rd_en, d1_pix_valid, d1_busy, d1_load_done, d1_scan_done;
    logic [15:0] d1_wr_addr, d1_rd_addr;
    logic [7:0]  d1_wr_data;
    logic [9:0]  d1_px_cnt, d1_line_cnt;

    frame_scan_ctrl u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(d0_in_ready), .wr_en(d0_wr_en), .wr_addr(d0_wr_addr), .wr_data(d0_wr_data),
        .out_ready(out_ready), .rd_en(d0_rd_en), .rd_addr(d0_rd_addr), .pix_valid(d0_pix_valid),
        .px_cnt(d0_px_cnt), .line_cnt(d0_line_cnt), .busy(d0_busy),
        .load_done(d0_load_done), .scan_done(d0_scan_done)
    );

    frame_scan_ctrl #(
        .FRAME_BYTES(S_FB), .HDR_BYTES(S_HB), .ROW_STRIDE(S_RS), .ACT_W(S_AW), .ACT_H(S_AH)
    ) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(d1_in_ready), .wr_en(d1_wr_en), .wr_addr(d1_wr_addr), .wr_data(d1_wr_data),
        .out_ready(out_ready), .rd_en(d1_rd_en), .rd_addr(d1_rd_addr), .pix_valid(d1_pix_valid),
        .px_cnt(d1_px_cnt), .line_cnt(d1_line_cnt), .busy(d1_busy),
        .load_done(d1_load_done), .scan_done(d1_scan_done)
    );

    logic        o_in_ready, o_wr_en, o_rd_en, o_pix_valid, o_busy, o_load_done, o_scan_done;
    logic [15:0] o_wr_addr, o_rd_addr;
    logic [7:0]  o_wr_data;
    logic [9:0]  o_px_cnt, o_line_cnt;
    assign o_in_ready  = sel ? d1_in_ready  : d0_in_ready;
    assign o_wr_en     = sel ? d1_wr_en     : d0_wr_en;
    assign o_wr_addr   = sel ? d1_wr_addr   : d0_wr_addr;
    assign o_wr_data   = sel ? d1_wr_data   : d0_wr_data;
    assign o_rd_en     = sel ? d1_rd_en     : d0_rd_en;
    assign o_rd_addr   = sel ? d1_rd_addr   : d0_rd_addr;
    assign o_pix_valid = sel ? d1_pix_valid : d0_pix_valid;
    assign o_px_cnt    = sel ? d1_px_cnt    : d0_px_cnt;
    assign o_line_cnt  = sel ? d1_line_cnt  : d0_line_cnt;
    assign o_busy      = sel ? d1_busy      : d0_busy;
    assign o_load_done = sel ? d1_load_done : d0_load_done;
    assign o_scan_done = sel ? d1_scan_done : d0_scan_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int fb, hb, rs, aw, ah;

    task automatic use_dut(input logic s);
        sel = s;
        if (s) begin
            fb = S_FB; hb = S_HB; rs = S_RS; aw = S_AW; ah = S_AH;
        end else begin
            fb = 36300; hb = 3330; rs = 330; aw = 300; ah = 100;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_byte = 8'($urandom);
        @(negedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if ({o_busy, o_in_ready, o_wr_en, o_rd_en, o_pix_valid, o_load_done, o_scan_done} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000000",
                     {o_busy, o_in_ready, o_wr_en, o_rd_en, o_pix_valid, o_load_done, o_scan_done});
        end
        n_cmp++;
        if ({o_wr_addr, o_rd_addr, o_wr_data, o_px_cnt, o_line_cnt} !== 60'd0) begin
            n_fail++;
            $display("FAIL reset_values got wa=%0d ra=%0d wd=%0d px=%0d ln=%0d want all 0",
                     o_wr_addr, o_rd_addr, o_wr_data, o_px_cnt, o_line_cnt);
        end
        @(negedge clk);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle got busy=%b in_ready=%b want 0 0", o_busy, o_in_ready);
        end
    endtask

    task automatic test_load(input int n_bytes);
        int cnt = 0;
        int cyc = 0;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++;
        if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle got busy=%b in_ready=%b want 0 0", o_busy, o_in_ready);
        end
        while (cnt < n_bytes) begin
            @(negedge clk);
            start    = ($urandom % 32) == 0;
            in_valid = ($urandom % 16) != 0;
            in_byte  = 8'($urandom);
            #1;
            n_cmp++;
            if (o_in_ready !== 1'b1 || o_wr_en !== in_valid || o_load_done !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL load_strobe byte %0d got rdy=%b wr_en=%b ld=%b busy=%b want 1 %b 0 1",
                         cnt, o_in_ready, o_wr_en, o_load_done, o_busy, in_valid);
            end
            if (in_valid) begin
                n_cmp++;
                if (o_wr_addr !== 16'(cnt) || o_wr_data !== in_byte) begin
                    n_fail++;
                    $display("FAIL load_write got addr=%0d data=%h want addr=%0d data=%h",
                             o_wr_addr, o_wr_data, cnt, in_byte);
                end
                cnt++;
            end
            cyc++;
            if (cyc > 4 * n_bytes + 100) begin
                n_fail++;
                $display("FAIL load_timeout got %0d bytes want %0d", cnt, n_bytes);
                break;
            end
        end
        if (n_bytes == fb) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
            #1;
            n_cmp++;
            if (o_load_done !== 1'b1 || o_in_ready !== 1'b0 || o_busy !== 1'b1 || o_rd_en !== 1'b0 ||
                o_rd_addr !== 16'(hb) || o_px_cnt !== 10'd0 || o_line_cnt !== 10'd0) begin
                n_fail++;
                $display("FAIL load_done got ld=%b rdy=%b busy=%b ra=%0d px=%0d ln=%0d want 1 0 1 %0d 0 0",
                         o_load_done, o_in_ready, o_busy, o_rd_addr, o_px_cnt, o_line_cnt, hb);
            end
        end
    endtask

    task automatic test_scan(input int stall_k, input int abort_line, input bit rand_ready);
        int   k = 0;
        int   cyc = 0;
        int   rd_seen = 0;
        int   stall_left = 0;
        bit   stalled = 0;
        logic prev_rd = 1'b0;
        int   total, r, c;
        logic [15:0] exp_addr;
        total = aw * ah;
        while (k < total) begin
            @(negedge clk);
            if (k == stall_k && !stalled) begin
                stall_left = 5;
                stalled    = 1;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = rand_ready ? (($urandom % 4) != 0) : 1'b1;
            end
            start = ($urandom % 64) == 0;
            r = k / aw;
            c = k % aw;
            exp_addr = 16'(hb + r * rs + c);
            if (abort_line >= 0 && r == abort_line) begin
                reset = 1'b1; out_ready = 1'b1; start = 1'b1;
                @(negedge clk);
                reset = 1'b0; start = 1'b0;
                #1;
                n_cmp++;
                if (o_busy !== 1'b0 || o_rd_en !== 1'b0 || o_pix_valid !== 1'b0 || o_in_ready !== 1'b0 ||
                    o_rd_addr !== 16'd0 || o_px_cnt !== 10'd0 || o_line_cnt !== 10'd0) begin
                    n_fail++;
                    $display("FAIL abort_idle got busy=%b rd_en=%b pv=%b ra=%0d px=%0d ln=%0d want 0 0 0 0 0 0",
                             o_busy, o_rd_en, o_pix_valid, o_rd_addr, o_px_cnt, o_line_cnt);
                end
                out_ready = 1'b0;
                return;
            end
            #1;
            n_cmp++;
            if (o_rd_en !== out_ready || o_rd_addr !== exp_addr || o_px_cnt !== 10'(c) ||
                o_line_cnt !== 10'(r) || o_pix_valid !== prev_rd) begin
                n_fail++;
                $display("FAIL scan_read got rd_en=%b ra=%0d px=%0d ln=%0d pv=%b want %b %0d %0d %0d %b",
                         o_rd_en, o_rd_addr, o_px_cnt, o_line_cnt, o_pix_valid,
                         out_ready, exp_addr, c, r, prev_rd);
            end
            n_cmp++;
            if (o_busy !== 1'b1 || o_load_done !== 1'b0 || o_scan_done !== 1'b0 || o_in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_flags got busy=%b ld=%b sd=%b rdy=%b want 1 0 0 0",
                         o_busy, o_load_done, o_scan_done, o_in_ready);
            end
            if (sel == 1'b0 && out_ready && (k == 0 || k == 300 || k == total - 1)) begin
                n_cmp++;
                if ((k == 0 && o_rd_addr !== 16'd3330) ||
                    (k == 300 && (o_rd_addr !== 16'd3660 || o_px_cnt !== 10'd0 || o_line_cnt !== 10'd1)) ||
                    (k == total - 1 && o_rd_addr !== 16'd36299)) begin
                    n_fail++;
                    $display("FAIL scan_landmark read %0d got ra=%0d px=%0d ln=%0d", k, o_rd_addr, o_px_cnt, o_line_cnt);
                end
            end
            if (o_rd_en === 1'b1) rd_seen++;
            prev_rd = out_ready;
            if (out_ready) k++;
            cyc++;
            if (cyc > 4 * total + 100) begin
                n_fail++;
                $display("FAIL scan_timeout got %0d reads want %0d", k, total);
                break;
            end
        end
        @(negedge clk);
        out_ready = 1'b1; start = 1'b0;
        #1;
        n_cmp++;
        if (o_scan_done !== 1'b1 || o_busy !== 1'b1 || o_rd_en !== 1'b0 || o_pix_valid !== prev_rd ||
            o_px_cnt !== 10'd0 || o_line_cnt !== 10'd0) begin
            n_fail++;
            $display("FAIL scan_done got sd=%b busy=%b rd_en=%b pv=%b px=%0d ln=%0d want 1 1 0 %b 0 0",
                     o_scan_done, o_busy, o_rd_en, o_pix_valid, o_px_cnt, o_line_cnt, prev_rd);
        end
        n_cmp++;
        if (rd_seen != total) begin
            n_fail++;
            $display("FAIL scan_reads got %0d rd_en pulses want %0d", rd_seen, total);
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_cmp++;
        if (o_scan_done !== 1'b0 || o_busy !== 1'b0 || o_pix_valid !== 1'b0 || o_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL scan_idle got sd=%b busy=%b pv=%b rd_en=%b want 0 0 0 0",
                     o_scan_done, o_busy, o_pix_valid, o_rd_en);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'd0; out_ready = 1'b0;
        use_dut(1'b0);
        repeat (2) @(negedge clk);
        test_reset();
        test_load(fb);
        test_scan(10 * aw + 150, -1, 1'b0);

        use_dut(1'b1);
        test_load(100);
        test_reset();
        test_load(fb);
        test_scan(-1, 50, 1'b1);
        test_load(fb);
        test_scan(-1, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
